// File: rtl/plab3_mem_line_mem_responder.sv
// Cacheline-granularity memory responder: one 128-bit val/rdy request at a time,
// accessed on the accepting edge, answered after a fixed programmable latency.
module plab3_mem_line_mem_responder #(
    parameter int p_mem_nbytes = 1024,
    parameter int p_latency    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [174:0] memreq_msg,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    output logic [142:0] memresp_msg,
    output logic         memresp_val,
    input  logic         memresp_rdy
);
    localparam int abw        = 32;
    localparam int clw        = 128;
    localparam int req_nbits  = 3 + 8 + abw + 4 + clw;
    localparam int resp_nbits = 3 + 8 + 4 + clw;
    localparam int nlines     = p_mem_nbytes / 16;
    localparam int idx_w      = (nlines > 1) ? $clog2(nlines) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [resp_nbits-1:0]   resp_q, resp_d;

    logic [clw-1:0]          mem [nlines];

    // Request field decode
    logic [2:0]              req_type;
    logic [7:0]              req_opaque;
    logic [abw-1:0]          req_addr;
    logic [3:0]              req_len;
    logic [clw-1:0]          req_data;
    logic [idx_w-1:0]        req_idx;
    logic [15:0]             byte_en;
    logic                    req_fire;
    logic                    req_is_write;
    logic                    unused_addr_lo;

    assign req_type   = memreq_msg[req_nbits-1 -: 3];
    assign req_opaque = memreq_msg[req_nbits-4 -: 8];
    assign req_addr   = memreq_msg[clw+4 +: abw];
    assign req_len    = memreq_msg[clw +: 4];
    assign req_data   = memreq_msg[clw-1:0];

    // Masking the line number gives the modulo-size address aliasing.
    assign req_idx        = idx_w'(req_addr[abw-1:4] & (abw-4)'(nlines - 1));
    assign unused_addr_lo = ^req_addr[3:0];

    assign req_fire     = memreq_val && (state_q == ST_IDLE);
    assign req_is_write = (req_type == 3'd1) || (req_type == 3'd2);

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            byte_en[i] = (req_len == 4'd0) || (4'(i) < req_len);
        end
    end

    // NOTE: the storage array has no reset; only control state is reset, and
    // line contents deliberately survive a reset.
    always_ff @(posedge clk) begin
        if (req_fire && req_is_write) begin
            for (int i = 0; i < 16; i++) begin
                if (byte_en[i]) begin
                    mem[req_idx][8*i +: 8] <= req_data[8*i +: 8];
                end
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (memreq_val) begin
                    resp_d = {req_type, req_opaque, req_len,
                              (req_type == 3'd0) ? mem[req_idx] : {clw{1'b0}}};
                    if (p_latency == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                    cnt_d = 4'(p_latency);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (memresp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign memreq_rdy  = (state_q == ST_IDLE);
    assign memresp_val = (state_q == ST_RESP);
    assign memresp_msg = resp_q;

endmodule
